fwd_sched: RTL and testbench
============================

Name: fwd_sched

Overview:
- Forwarding scheduler for the RV32 five-stage pipeline.
- Tracks the destination register of every in-flight instruction (EX, MEM, WB slots) and drives the select codes for the two EX-stage operand 3:1 muxes:
  - 00: register-file value
  - 10: MEM-stage result
  - 11: WB-stage result
- Detects load-use hazards, requests a one-cycle stall and inserts a bubble.
- Sits between the ID decode logic and the EX operand muxes.

Parameters:
- REG_ADDR_W, 5, register index width.
- STAT_W, 16, width of the statistics counters (used only with the optional feature).

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- id_valid_in  input  1  ID holds a valid instruction.
- id_rs1_in  input  REG_ADDR_W  ID source register 1.
- id_rs2_in  input  REG_ADDR_W  ID source register 2.
- id_rd_in  input  REG_ADDR_W  ID destination register.
- id_reg_wr_in  input  1  ID instruction writes rd.
- id_mem_rd_in  input  1  ID instruction is a load.
- hold_in  input  1  global pipeline freeze (e.g. memory wait).
- flush_in  input  1  squash ID and EX (taken branch/jump).
- fwd_a_sel_out  output  2  operand-A mux select for the instruction now in EX.
- fwd_b_sel_out  output  2  operand-B mux select for the instruction now in EX.
- stall_out  output  1  load-use stall request to PC/IF/ID (combinational).

Behaviour:
- Internal slots ex/mem/wb each hold {valid, rd, reg_wr, mem_rd}.
- A slot is a "writer" iff valid & reg_wr & rd != 0.
- Reset: all slots invalid, fwd_a_sel_out = fwd_b_sel_out = 2'b00, stall_out = 0. Reset mid-operation discards all in-flight state immediately.
- Hazard: hz = id_valid_in & ex writer & ex.mem_rd & rs matches ex.rd, evaluated for rs1 and rs2, rs != 0.
- stall_out = hz & ~flush_in. Combinational from current state and ID inputs; not gated by hold_in.
- Select computation in ID, registered into EX, so outputs are valid for the whole EX cycle. Per operand rs:
  - if rs == 0, select 00;
  - else if the ex slot is a writer and ex.rd == rs, select 10 (producer will be in MEM);
  - else if the mem slot is a writer and mem.rd == rs, select 11;
  - else select 00.
- The nearest producer wins: a double match selects 10.
- The wb slot never forwards, because the regfile is written by then. It is still tracked, and retires each cycle.
- Per-edge update, in priority order:
  - hold_in = 1: all slots and outputs keep their values.
  - flush_in = 1: mem <= ex, wb <= mem, ex <= bubble, both sels <= 00.
  - stall_out = 1: mem <= ex, wb <= mem, ex <= bubble, both sels <= 00. The ID instruction is re-evaluated next cycle; the load is then in the mem slot, so it gets select 11.
  - otherwise: ex <= ID fields (valid = id_valid_in), mem <= ex, wb <= mem, sels <= computed values.
- Invalid ID (id_valid_in = 0): ex <= bubble, sels <= 00.
- Latency: one cycle from ID inputs to sel outputs. A load-use pair costs exactly one bubble.
- Back-to-back writers of the same rd: the youngest wins, per the priority above.

Optional Feature:
- Macro FWD_SCHED_STATS_EN.
- When defined, adds three outputs of width STAT_W:
  - stat_fwd_mem_out: edges where any sel was loaded with 10;
  - stat_fwd_wb_out: edges where any sel was loaded with 11;
  - stat_stall_out: edges where stall_out = 1 and hold_in = 0.
- Counter rules:
  - all three reset to 0;
  - each saturates at all-ones;
  - none increments during hold_in or flush_in.
- When not defined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- EX→EX forward: cycle 0 ID add x5 (rd = 5, reg_wr = 1); cycle 1 ID sub, rs1 = 5, rs2 = 6 → cycle 2 fwd_a_sel_out = 10, fwd_b_sel_out = 00, stall_out never 1.
- MEM→EX forward and priority:
  - writes to x7 at cycles 0 and 1, consumer rs2 = 7 at cycle 2 → cycle 3 fwd_b_sel_out = 10 (nearest producer);
  - with the cycle-1 writer replaced by a nop → fwd_b_sel_out = 11.
- Load-use: cycle 0 ID lw x3; cycle 1 ID add, rs1 = 3 → stall_out = 1 in cycle 1; cycle 2 sels 00 (bubble) and ID re-evaluated, stall_out = 0; cycle 3 fwd_a_sel_out = 11.
- x0 and flush:
  - writer rd = 0, consumer rs1 = 0 → sel 00;
  - flush_in asserted during a load-use stall → stall_out = 0 and next-cycle sels 00.
- hold_in: set up a pending forward, then assert hold_in for 3 cycles → sels and slots frozen; after release the forwarding outcome matches an unheld run.
- Reset: assert rst_n = 0 asynchronously mid-stream with stall_out = 1 → all outputs 0 before the next edge; with the stats macro defined, counters read 0.

Source files
------------

// File: rtl/fwd_sched.sv
// rtl/fwd_sched.sv - RV32 five-stage forwarding scheduler: EX operand mux selects and load-use stall
// Optional feature macro: FWD_SCHED_STATS_EN (adds forwarding/stall statistics counters)
// Ports:
//   clk, rst_n                     pipeline clock (rising edge), asynchronous active-low reset
//   id_valid_in                    ID holds a valid instruction
//   id_rs1_in, id_rs2_in           ID source registers
//   id_rd_in, id_reg_wr_in         ID destination register and its write enable
//   id_mem_rd_in                   ID instruction is a load
//   hold_in                        global freeze: slots and selects keep their values
//   flush_in                       squash ID and EX
//   fwd_a_sel_out, fwd_b_sel_out   EX operand selects: 00 regfile, 10 MEM result, 11 WB result
//   stall_out                      load-use stall request to PC/IF/ID (combinational)
//   stat_fwd_mem_out               edges loading a 10 select (FWD_SCHED_STATS_EN only)
//   stat_fwd_wb_out                edges loading an 11 select (FWD_SCHED_STATS_EN only)
//   stat_stall_out                 unheld load-use stall edges (FWD_SCHED_STATS_EN only)
module fwd_sched #(
  parameter int REG_ADDR_W = 5,
  parameter int STAT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid_in,
  input  logic [REG_ADDR_W-1:0] id_rs1_in,
  input  logic [REG_ADDR_W-1:0] id_rs2_in,
  input  logic [REG_ADDR_W-1:0] id_rd_in,
  input  logic                  id_reg_wr_in,
  input  logic                  id_mem_rd_in,
  input  logic                  hold_in,
  input  logic                  flush_in,
  output logic [1:0]            fwd_a_sel_out,
  output logic [1:0]            fwd_b_sel_out,
  output logic                  stall_out
`ifdef FWD_SCHED_STATS_EN
  ,
  output logic [STAT_W-1:0]     stat_fwd_mem_out,
  output logic [STAT_W-1:0]     stat_fwd_wb_out,
  output logic [STAT_W-1:0]     stat_stall_out
`endif
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_WB  = 2'b11;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_wr;
    logic                  mem_rd;
  } slot_t;

  slot_t ex_slot, mem_slot, wb_slot;
  slot_t id_slot;

  logic       ex_writer, mem_writer;
  logic       hz_a, hz_b;
  logic [1:0] nxt_a_sel, nxt_b_sel;

  assign ex_writer  = ex_slot.valid  & ex_slot.reg_wr  & (ex_slot.rd  != '0);
  assign mem_writer = mem_slot.valid & mem_slot.reg_wr & (mem_slot.rd != '0);

  // A load still in EX cannot supply its data to the instruction behind it.
  assign hz_a = id_valid_in & ex_writer & ex_slot.mem_rd &
                (id_rs1_in != '0) & (id_rs1_in == ex_slot.rd);
  assign hz_b = id_valid_in & ex_writer & ex_slot.mem_rd &
                (id_rs2_in != '0) & (id_rs2_in == ex_slot.rd);

  assign stall_out = (hz_a | hz_b) & ~flush_in;

  // An invalid ID instruction enters EX as an all-zero bubble.
  always_comb begin
    id_slot = '0;
    if (id_valid_in) begin
      id_slot.valid  = 1'b1;
      id_slot.rd     = id_rd_in;
      id_slot.reg_wr = id_reg_wr_in;
      id_slot.mem_rd = id_mem_rd_in;
    end
  end

  // Nearest producer wins: the EX slot is checked before the MEM slot.
  // The WB slot never forwards since the regfile already holds its value.
  always_comb begin
    nxt_a_sel = SEL_RF;
    nxt_b_sel = SEL_RF;
    if (id_valid_in) begin
      if (id_rs1_in == '0)
        nxt_a_sel = SEL_RF;
      else if (ex_writer && (ex_slot.rd == id_rs1_in))
        nxt_a_sel = SEL_MEM;
      else if (mem_writer && (mem_slot.rd == id_rs1_in))
        nxt_a_sel = SEL_WB;

      if (id_rs2_in == '0)
        nxt_b_sel = SEL_RF;
      else if (ex_writer && (ex_slot.rd == id_rs2_in))
        nxt_b_sel = SEL_MEM;
      else if (mem_writer && (mem_slot.rd == id_rs2_in))
        nxt_b_sel = SEL_WB;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_slot       <= '0;
      mem_slot      <= '0;
      wb_slot       <= '0;
      fwd_a_sel_out <= SEL_RF;
      fwd_b_sel_out <= SEL_RF;
    end else if (!hold_in) begin
      mem_slot <= ex_slot;
      wb_slot  <= mem_slot;
      if (flush_in || stall_out) begin
        ex_slot       <= '0;
        fwd_a_sel_out <= SEL_RF;
        fwd_b_sel_out <= SEL_RF;
      end else begin
        ex_slot       <= id_slot;
        fwd_a_sel_out <= nxt_a_sel;
        fwd_b_sel_out <= nxt_b_sel;
      end
    end
  end

  // The WB slot is kept for pipeline visibility only; nothing here consumes it.
  logic wb_unused;
  assign wb_unused = ^wb_slot;

`ifdef FWD_SCHED_STATS_EN
  logic sel_load, hit_mem, hit_wb, hit_stall;

  // Computed selects are only loaded on an unheld, unflushed, unstalled edge.
  assign sel_load  = ~hold_in & ~flush_in & ~stall_out;
  assign hit_mem   = sel_load & ((nxt_a_sel == SEL_MEM) | (nxt_b_sel == SEL_MEM));
  assign hit_wb    = sel_load & ((nxt_a_sel == SEL_WB)  | (nxt_b_sel == SEL_WB));
  assign hit_stall = stall_out & ~hold_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_fwd_mem_out <= '0;
      stat_fwd_wb_out  <= '0;
      stat_stall_out   <= '0;
    end else begin
      if (hit_mem && (stat_fwd_mem_out != '1))
        stat_fwd_mem_out <= stat_fwd_mem_out + STAT_W'(1);
      if (hit_wb && (stat_fwd_wb_out != '1))
        stat_fwd_wb_out <= stat_fwd_wb_out + STAT_W'(1);
      if (hit_stall && (stat_stall_out != '1))
        stat_stall_out <= stat_stall_out + STAT_W'(1);
    end
  end
`else
  localparam int stat_w_unused = STAT_W;
`endif

endmodule

// File: tb/tb_fwd_sched.sv
// tb/tb_fwd_sched.sv - scoreboard bench for fwd_sched with directed forwarding/stall vectors
module tb_fwd_sched;

  localparam logic [1:0] RF  = 2'b00;
  localparam logic [1:0] MEM = 2'b10;
  localparam logic [1:0] WB  = 2'b11;

  logic       clk;
  logic       rst_n;
  logic       id_valid_in;
  logic [4:0] id_rs1_in, id_rs2_in, id_rd_in;
  logic       id_reg_wr_in, id_mem_rd_in;
  logic       hold_in, flush_in;
  logic [1:0] fwd_a_sel_out, fwd_b_sel_out;
  logic       stall_out;
`ifdef FWD_SCHED_STATS_EN
  logic [15:0] stat_fwd_mem_out, stat_fwd_wb_out, stat_stall_out;
`endif

  fwd_sched #(.REG_ADDR_W(5), .STAT_W(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_valid_in   (id_valid_in),
    .id_rs1_in     (id_rs1_in),
    .id_rs2_in     (id_rs2_in),
    .id_rd_in      (id_rd_in),
    .id_reg_wr_in  (id_reg_wr_in),
    .id_mem_rd_in  (id_mem_rd_in),
    .hold_in       (hold_in),
    .flush_in      (flush_in),
    .fwd_a_sel_out (fwd_a_sel_out),
    .fwd_b_sel_out (fwd_b_sel_out),
    .stall_out     (stall_out)
`ifdef FWD_SCHED_STATS_EN
    ,
    .stat_fwd_mem_out (stat_fwd_mem_out),
    .stat_fwd_wb_out  (stat_fwd_wb_out),
    .stat_stall_out   (stat_stall_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] a;
    logic [1:0] b;
    logic       s;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks   = 0;
  int    failures = 0;
  bit    done     = 1'b0;
  bit    drained  = 1'b0;

  // Monitor: one expected entry per cycle, compared mid-cycle on the falling edge.
  always @(negedge clk) begin
    exp_t  e;
    string n;
`ifdef FWD_SCHED_STATS_EN
    if (!rst_n) begin
      checks++;
      if ({stat_fwd_mem_out, stat_fwd_wb_out, stat_stall_out} !== 48'd0) begin
        failures++;
        $display("FAIL stats_in_reset got mem=%0d wb=%0d stall=%0d exp all 0",
                 stat_fwd_mem_out, stat_fwd_wb_out, stat_stall_out);
      end
    end
`endif
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (fwd_a_sel_out !== e.a) begin
        failures++;
        $display("FAIL %s fwd_a_sel got=%b exp=%b", n, fwd_a_sel_out, e.a);
      end
      checks++;
      if (fwd_b_sel_out !== e.b) begin
        failures++;
        $display("FAIL %s fwd_b_sel got=%b exp=%b", n, fwd_b_sel_out, e.b);
      end
      checks++;
      if (stall_out !== e.s) begin
        failures++;
        $display("FAIL %s stall got=%b exp=%b", n, stall_out, e.s);
      end
    end else if (done && !drained) begin
      drained = 1'b1;
      checks++;
      if (exp_q.size() != 0) begin
        failures++;
        $display("FAIL scoreboard_drain got=%0d pending exp=0", exp_q.size());
      end
    end
  end

  task automatic push_exp(input logic [1:0] ea, input logic [1:0] eb, input logic es,
                          input string n);
    exp_t e;
    e.a = ea;
    e.b = eb;
    e.s = es;
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic wr, input logic mrd,
                       input logic hold, input logic flush);
    id_valid_in  = v;
    id_rs1_in    = rs1;
    id_rs2_in    = rs2;
    id_rd_in     = rd;
    id_reg_wr_in = wr;
    id_mem_rd_in = mrd;
    hold_in      = hold;
    flush_in     = flush;
  endtask

  // One pipeline cycle: apply ID/control inputs, queue what the outputs must show this cycle.
  task automatic cyc(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [4:0] rd, input logic wr, input logic mrd,
                     input logic hold, input logic flush,
                     input logic [1:0] ea, input logic [1:0] eb, input logic es,
                     input string n);
    drive(v, rs1, rs2, rd, wr, mrd, hold, flush);
    push_exp(ea, eb, es, n);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string n, input logic [1:0] ea, input logic [1:0] eb);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, ea, eb, 0, n);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    push_exp(RF, RF, 0, "reset_state");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // EX->EX forward
    cyc(1, 1, 2, 5, 1, 0, 0, 0, RF, RF, 0, "ex_fwd_c0");
    cyc(1, 5, 6, 8, 1, 0, 0, 0, RF, RF, 0, "ex_fwd_c1");
    idle("ex_fwd_c2", MEM, RF);
    idle("ex_fwd_c3", RF, RF);
    idle("gap", RF, RF);

    // Two writers of x7: nearest wins
    cyc(1, 0, 0, 7, 1, 0, 0, 0, RF, RF, 0, "prio_w0");
    cyc(1, 0, 0, 7, 1, 0, 0, 0, RF, RF, 0, "prio_w1");
    cyc(1, 9, 7, 10, 1, 0, 0, 0, RF, RF, 0, "prio_use");
    idle("prio_near", RF, MEM);
    idle("gap", RF, RF);
    idle("gap", RF, RF);

    // Writer, nop, consumer: MEM slot forwards
    cyc(1, 0, 0, 7, 1, 0, 0, 0, RF, RF, 0, "wbsel_w0");
    cyc(1, 0, 0, 0, 1, 0, 0, 0, RF, RF, 0, "wbsel_nop");
    cyc(1, 9, 7, 10, 1, 0, 0, 0, RF, RF, 0, "wbsel_use");
    idle("wbsel_far", RF, WB);
    idle("gap", RF, RF);
    idle("gap", RF, RF);

    // Load-use: one bubble then forward from the MEM slot
    cyc(1, 2, 0, 3, 1, 1, 0, 0, RF, RF, 0, "lu_load");
    cyc(1, 3, 4, 11, 1, 0, 0, 0, RF, RF, 1, "lu_stall");
    cyc(1, 3, 4, 11, 1, 0, 0, 0, RF, RF, 0, "lu_bubble");
    idle("lu_fwd", WB, RF);
    idle("gap", RF, RF);
    idle("gap", RF, RF);

    // x0 is never a producer, not even for a load
    cyc(1, 0, 0, 0, 1, 1, 0, 0, RF, RF, 0, "x0_load");
    cyc(1, 0, 0, 12, 1, 0, 0, 0, RF, RF, 0, "x0_use");
    idle("x0_sel", RF, RF);
    idle("gap", RF, RF);

    // Flush masks a load-use stall and squashes a pending forward
    cyc(1, 2, 0, 3, 1, 1, 0, 0, RF, RF, 0, "fl_load");
    cyc(1, 3, 3, 11, 1, 0, 0, 1, RF, RF, 0, "fl_stall_masked");
    idle("fl_sels", RF, RF);
    cyc(1, 1, 1, 5, 1, 0, 0, 0, RF, RF, 0, "fl_wr");
    cyc(1, 5, 5, 13, 1, 0, 0, 1, RF, RF, 0, "fl_use_flushed");
    idle("fl_sels2", RF, RF);
    idle("gap", RF, RF);
    idle("gap", RF, RF);

    // Hold freezes slots and selects for three cycles
    cyc(1, 1, 2, 5, 1, 0, 0, 0, RF, RF, 0, "hd_wr");
    cyc(1, 5, 5, 12, 1, 0, 0, 0, RF, RF, 0, "hd_use");
    cyc(1, 12, 5, 13, 1, 0, 1, 0, MEM, MEM, 0, "hd_h1");
    cyc(1, 12, 5, 13, 1, 0, 1, 0, MEM, MEM, 0, "hd_h2");
    cyc(1, 12, 5, 13, 1, 0, 1, 0, MEM, MEM, 0, "hd_h3");
    cyc(1, 12, 5, 13, 1, 0, 0, 0, MEM, MEM, 0, "hd_rel");
    idle("hd_after", MEM, WB);
    idle("gap", RF, RF);
    idle("gap", RF, RF);

    // Asynchronous reset while a stall is being requested
    cyc(1, 0, 0, 2, 1, 0, 0, 0, RF, RF, 0, "rs_wr");
    cyc(1, 2, 2, 3, 1, 1, 0, 0, RF, RF, 0, "rs_load");
    cyc(1, 3, 0, 11, 1, 0, 0, 0, MEM, MEM, 1, "rs_stall");
    drive(1, 3, 0, 11, 1, 0, 1, 0);
    push_exp(RF, RF, 0, "rs_async");
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(1, 3, 0, 11, 1, 0, 0, 0, RF, RF, 0, "rs_post");
    idle("rs_post_sel", RF, RF);
    idle("tail", RF, RF);

    done = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
